uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial-to-parallel UART receiver, 8N1 framing, LSB first, idle-high line. It is the receive counterpart to the team's UART transmitter inside tt_um_ultrasword_jonz9. The serial input comes from a ui_in pin; the received byte is presented to the user logic through a valid/ready holding register. Start-bit glitches, framing errors and overrun are detected and reported.

Parameters:
CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200); legal range >= 4
HALF_BIT, CLKS_PER_BIT/2 (floor), derived; cycles from start edge to start-bit mid-sample

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
rx  input  1  asynchronous serial line, idle high
rx_data  output  8  received byte; held stable while rx_valid=1
rx_valid  output  1  holding register full
rx_ready  input  1  consumer accept; transfer occurs when rx_valid & rx_ready
busy  output  1  high whenever FSM is not in IDLE
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  sticky: a good byte completed while rx_valid=1

Behaviour:
- Reset (rst_n=0 at a clk edge): FSM=IDLE; synchroniser flops=1; rx_data=0x00; rx_valid=0; busy=0; frame_err=0; overrun=0; all counters=0. Reset mid-frame aborts the frame with no output.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s, so there are 2 cycles of input latency.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: on rx_s=0, go to START and clear the cycle counter.
- START: count HALF_BIT-1 cycles, then sample rx_s. If 0, go to DATA with bit index 0 and the counter cleared. If 1, treat it as a glitch: return to IDLE with no flags.
- DATA: sample every CLKS_PER_BIT cycles (mid-bit). Shift the sample into bit[index], LSB first. After index 7, go to STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - Sample=1 and rx_valid=0 (after the handshake in the same cycle is applied): load rx_data and set rx_valid.
  - Sample=1 and rx_valid still 1: discard the new byte and set overrun. rx_data is unchanged.
  - In both sample=1 cases, go to IDLE.
  - Sample=0: pulse frame_err for exactly 1 cycle, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. This covers break conditions; no repeated frame_err.
- rx_valid/rx_data timing: both update on the clk edge that takes the stop-bit sample. From the stop-bit mid-point on rx_s, rx_valid is high 1 cycle later.
- Handshake: rx_valid clears on the edge where rx_valid & rx_ready=1. rx_ready while rx_valid=0 is ignored.
- Simultaneous accept and stop-sample in the same cycle: the old byte is consumed, the new byte is loaded, rx_valid stays 1, and no overrun.
- overrun clears only on reset, or on a handshake with no simultaneous new overrun.
- busy = (state != IDLE), registered with the state.
- Back-to-back frames: a start edge is recognised on the first IDLE cycle after STOP. Receiver stop-bit tolerance is 1/2 bit.
- Counter width: $clog2(CLKS_PER_BIT). Bit index is 3 bits. No arithmetic overflow is possible within legal parameters.

Test Plan:
1. CLKS_PER_BIT=16, rst_n low 16 cycles with rx=1 -> all outputs 0, busy=0. Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) -> rx_valid=1, rx_data=0xA5, frame_err=0. Hold rx_ready=0 -> data stays; pulse rx_ready -> rx_valid=0 next cycle.
2. Back-to-back 0x00, 0xFF, 0x55 with rx_ready tied 1 -> three rx_valid pulses with matching data, no overrun. busy is high during each frame.
3. rx low for 4 cycles (< HALF_BIT), then high -> FSM returns to IDLE. No rx_valid, no frame_err.
4. Frame 0x3C with stop bit driven 0, then line held low 40 cycles -> exactly one frame_err pulse, rx_valid stays 0. Line returns high, then 0x81 is sent -> rx_data=0x81.
5. rx_ready=0; send 0x12 then 0x34 -> rx_data=0x12, overrun=1. Assert rx_ready -> rx_valid=0, overrun=0.
6. Assert rx_ready on the same cycle the 2nd byte's stop sample occurs -> rx_data becomes the 2nd byte, rx_valid remains 1, overrun=0. Separately, assert rst_n=0 during DATA bit 3 -> outputs reset, and the next clean frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side byte handshake between uart_rx (master) and the consuming logic (slave).
// rx_data is only meaningful while rx_valid is high; frame_err and overrun ride alongside.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line, mid-bit sampling after a 2-flop synchroniser.
// A received byte lands in a valid/ready holding register; glitches, framing errors and overrun are flagged.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     rx,
    output logic     busy,
    uart_rx_if.master bus
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    idx_reg;
    logic [7:0]    shift_reg;
    logic          rx_meta_reg;
    logic          rx_s_reg;
    logic [7:0]    data_reg;
    logic          valid_reg;
    logic          ferr_reg;
    logic          ovr_reg;
    logic          busy_reg;
    logic          accept;

    assign accept        = valid_reg & bus.rx_ready;
    assign bus.rx_data   = data_reg;
    assign bus.rx_valid  = valid_reg;
    assign bus.frame_err = ferr_reg;
    assign bus.overrun   = ovr_reg;
    assign busy          = busy_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            shift_reg   <= '0;
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
            ovr_reg     <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
            ferr_reg    <= 1'b0;

            // Consumer handshake first; a stop-bit load later in this block overrides it.
            if (accept) begin
                valid_reg <= 1'b0;
                ovr_reg   <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (!rx_s_reg) begin
                        state_reg <= START;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= '0;
                    end
                end
                START: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg <= '0;
                        if (!rx_s_reg) begin
                            state_reg <= DATA;
                            idx_reg   <= '0;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg            <= '0;
                        shift_reg[idx_reg] <= rx_s_reg;
                        idx_reg            <= idx_reg + 3'd1;
                        if (idx_reg == 3'd7) begin
                            state_reg <= STOP;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg <= '0;
                        if (rx_s_reg) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                            if (valid_reg && !accept) begin
                                ovr_reg <= 1'b1;
                            end else begin
                                data_reg  <= shift_reg;
                                valid_reg <= 1'b1;
                            end
                        end else begin
                            ferr_reg  <= 1'b1;
                            state_reg <= WAIT_IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    // Break or stuck-low line: no further error pulses until it goes idle.
                    if (rx_s_reg) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames, checked every cycle against a
// frame-level timeline model (expected load/error edges and busy windows derived from what was sent).
module tb_uart_rx;
    localparam int C    = 16;
    localparam int H    = C / 2;
    localparam int MAXC = 30000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic busy;

    uart_rx_if bus();

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Timeline of expected events, indexed by rising-edge number.
    bit         ev_load  [MAXC];
    logic [7:0] ev_byte  [MAXC];
    bit         ev_ferr  [MAXC];
    bit         busy_arr [MAXC];

    int         cyc    = 0;
    int         checks = 0;
    int         fails  = 0;
    int         ferr_cnt = 0;
    bit         armed  = 1'b0;
    bit         rand_on = 1'b0;
    logic [7:0] got_q[$];

    logic       exp_valid = 1'b0;
    logic [7:0] exp_data  = 8'h00;
    logic       exp_ovr   = 1'b0;
    logic       exp_ferr  = 1'b0;
    logic       exp_busy  = 1'b0;

    // Holding-register model: apply this edge's handshake and any scheduled stop-bit outcome.
    always @(posedge clk) begin
        bit acc;
        cyc = cyc + 1;
        if (!rst_n) begin
            exp_valid = 1'b0;
            exp_data  = 8'h00;
            exp_ovr   = 1'b0;
            exp_ferr  = 1'b0;
            exp_busy  = 1'b0;
            armed     = 1'b1;
        end else begin
            acc      = exp_valid && bus.rx_ready;
            exp_ferr = (cyc < MAXC) && ev_ferr[cyc];
            exp_busy = (cyc < MAXC) && busy_arr[cyc];
            if (cyc < MAXC && ev_load[cyc]) begin
                if (exp_valid && !acc) begin
                    exp_ovr = 1'b1;
                end else begin
                    exp_data  = ev_byte[cyc];
                    exp_valid = 1'b1;
                    if (acc) exp_ovr = 1'b0;
                end
            end else if (acc) begin
                exp_valid = 1'b0;
                exp_ovr   = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if (bus.rx_valid !== exp_valid || bus.rx_data !== exp_data || bus.overrun !== exp_ovr ||
                bus.frame_err !== exp_ferr || busy !== exp_busy) begin
                fails++;
                $display("FAIL cycle %0d: valid %b/%b data %h/%h overrun %b/%b frame_err %b/%b busy %b/%b (dut/model)",
                         cyc, bus.rx_valid, exp_valid, bus.rx_data, exp_data, bus.overrun, exp_ovr,
                         bus.frame_err, exp_ferr, busy, exp_busy);
            end
            if (bus.frame_err === 1'b1) ferr_cnt++;
            if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) got_q.push_back(bus.rx_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
        $display("check %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic void mark_busy(input int a, input int b);
        for (int i = a; i <= b; i++) begin
            if (i >= 0 && i < MAXC) busy_arr[i] = 1'b1;
        end
    endfunction

    // Line low seen by the receiver's decision logic 3 edges after being driven (2 sync flops).
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int hold_low);
        int s, e0, es, r;
        s  = cyc;
        e0 = s + 3;
        es = e0 + H + 9 * C;
        if (stop_ok) begin
            mark_busy(e0, es - 1);
            if (es < MAXC) begin
                ev_load[es] = 1'b1;
                ev_byte[es] = b;
            end
        end else begin
            r = s + 10 * C + hold_low;
            mark_busy(e0, r + 2);
            if (es < MAXC) ev_ferr[es] = 1'b1;
        end
        rx = 1'b0;
        repeat (C) tick();
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (C) tick();
        end
        rx = stop_ok;
        repeat (C) tick();
        if (!stop_ok) begin
            repeat (hold_low) tick();
            rx = 1'b1;
            tick();
        end
        $display("frame %h stop_ok=%0d hold_low=%0d start_edge=%0d", b, stop_ok, hold_low, s);
    endtask

    task automatic glitch(input int g);
        int e0;
        e0 = cyc + 3;
        mark_busy(e0, e0 + H - 1);
        rx = 1'b0;
        repeat (g) tick();
        rx = 1'b1;
        repeat (H + 2) tick();
        $display("glitch low=%0d cycles start_edge=%0d", g, e0 - 3);
    endtask

    task automatic do_reset(input int n);
        for (int i = cyc + 1; i < MAXC; i++) begin
            ev_load[i]  = 1'b0;
            ev_ferr[i]  = 1'b0;
            busy_arr[i] = 1'b0;
        end
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (n) tick();
        rst_n = 1'b1;
        $display("reset for %0d cycles at edge %0d", n, cyc);
    endtask

    task automatic pulse_ready();
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t2_exp [3];
        int es, f0, r;
        t2_exp = '{8'h00, 8'hFF, 8'h55};
        bus.rx_ready = 1'b0;

        // 1: reset, single byte, hold then accept
        repeat (16) tick();
        check("reset_valid", bus.rx_valid, 0);
        check("reset_data", bus.rx_data, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", bus.overrun, 0);
        check("reset_frame_err", bus.frame_err, 0);
        rst_n = 1'b1;
        repeat (5) tick();
        send_frame(8'hA5, 1'b1, 0);
        check("t1_valid", bus.rx_valid, 1);
        check("t1_data", bus.rx_data, 8'hA5);
        repeat (10) tick();
        check("t1_hold_data", bus.rx_data, 8'hA5);
        pulse_ready();
        check("t1_accept_valid", bus.rx_valid, 0);

        // 2: back-to-back with consumer always ready
        got_q.delete();
        bus.rx_ready = 1'b1;
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        send_frame(8'h55, 1'b1, 0);
        repeat (4) tick();
        check("t2_count", got_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < got_q.size()) check("t2_byte", got_q[i], t2_exp[i]);
        end
        check("t2_overrun", bus.overrun, 0);
        bus.rx_ready = 1'b0;

        // 3: short start glitch
        f0 = ferr_cnt;
        glitch(4);
        check("t3_valid", bus.rx_valid, 0);
        check("t3_busy", busy, 0);
        check("t3_ferr", ferr_cnt - f0, 0);

        // 4: framing error with a held-low line, then a clean frame
        send_frame(8'h3C, 1'b0, 40);
        repeat (3) tick();
        check("t4_ferr_pulses", ferr_cnt - f0, 1);
        check("t4_valid", bus.rx_valid, 0);
        send_frame(8'h81, 1'b1, 0);
        check("t4_data", bus.rx_data, 8'h81);
        pulse_ready();

        // 5: overrun
        send_frame(8'h12, 1'b1, 0);
        send_frame(8'h34, 1'b1, 0);
        check("t5_data", bus.rx_data, 8'h12);
        check("t5_overrun", bus.overrun, 1);
        pulse_ready();
        check("t5_valid", bus.rx_valid, 0);
        check("t5_overrun_clr", bus.overrun, 0);

        // 6a: accept on the same edge as the next stop-bit sample
        send_frame(8'h11, 1'b1, 0);
        es = cyc + 3 + H + 9 * C;
        fork
            send_frame(8'h22, 1'b1, 0);
            begin
                wait (cyc == es - 1);
                #1 bus.rx_ready = 1'b1;
                tick();
                bus.rx_ready = 1'b0;
            end
        join
        check("t6_data", bus.rx_data, 8'h22);
        check("t6_valid", bus.rx_valid, 1);
        check("t6_overrun", bus.overrun, 0);
        pulse_ready();

        // 6b: reset in the middle of data bit 3, then a clean frame
        mark_busy(cyc + 3, cyc + 3 + H + 9 * C);
        rx = 1'b0;
        repeat (C) tick();
        for (int k = 0; k < 4; k++) begin
            r = (8'h5A >> k) & 1;
            rx = r[0];
            repeat ((k == 3) ? C / 2 : C) tick();
        end
        do_reset(4);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_data", bus.rx_data, 0);
        repeat (4) tick();
        send_frame(8'hC3, 1'b1, 0);
        check("t6_c3_data", bus.rx_data, 8'hC3);
        check("t6_c3_valid", bus.rx_valid, 1);
        pulse_ready();

        // Random frames, glitches and framing errors with a sparse random consumer
        rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    if (rand_on) bus.rx_ready = ($urandom_range(0, 5) == 0);
                end
            end
        join_none
        for (int n = 0; n < 30; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) glitch($urandom_range(1, H));
            else send_frame(8'($urandom_range(0, 255)), sel != 1, $urandom_range(0, 40));
            repeat ($urandom_range(1, 20)) tick();
        end
        rand_on = 1'b0;
        tick();
        bus.rx_ready = 1'b1;
        repeat (5) tick();
        check("final_valid", bus.rx_valid, 0);
        check("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
